fetch_queue: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the execution stage. Holds the fetch PC, issues word reads to the instruction TCM (`itcm`), and buffers returned instructions in a small queue. Presents them to execution as `inst_v_i`/`pc_i`/`inst_i` with a valid/ready handshake. Accepts taken-branch/jump redirects (`pc_v_x`/`pc_x`) from execution; a redirect flushes all buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 134 +++++++++++++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I core front end.
//   XLEN          : address / data width
//   ILEN          : instruction width
//   fetch_entry_t : one buffered fetch result {pc, inst}
//   word_align()  : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary. Masking (rather than slicing)
    // keeps every input bit referenced.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer of fetch_entry_t. The head entry and its valid
// flag are held in registers so the consumer sees register outputs only.
// A push into an empty buffer becomes visible on the following cycle.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   flush         : drop all entries (priority over push/pop)
//   push/push_data: write one entry (caller ensures space, or a same-cycle pop)
//   pop           : retire the head (ignored when empty)
//   count         : number of stored entries
//   head_v/head   : registered head valid and entry
// ----------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_v,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             head_v_r;
    fetch_entry_t     head_r;

    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             head_v_nxt_s;
    fetch_entry_t     head_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Circular pointer increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state computation for pointers, occupancy and the registered head.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_v_nxt_s = 1'b0;
        head_nxt_s   = '0;

        do_pop_s  = pop && head_v_r;
        do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);

        if (do_push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (do_pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        // The new head is either already stored, or it is the entry being
        // written this cycle (only when the buffer drains down to it).
        if (count_nxt_s == CNT_W'(0)) begin
            head_v_nxt_s = 1'b0;
            head_nxt_s   = '0;
        end else if (do_push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_v_nxt_s = 1'b1;
            head_nxt_s   = push_data;
        end else begin
            head_v_nxt_s = 1'b1;
            head_nxt_s   = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage; stale contents are harmless because the pointers decide
    // what is live.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_v_r <= 1'b0;
            head_r   <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_v_r <= 1'b0;
            head_r   <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_v_r <= head_v_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

    assign count  = count_r;
    assign head_v = head_v_r;
    assign head   = head_r;

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch stage: owns the fetch PC, issues word reads to the ITCM
// (fixed one-cycle read latency, always ready) and buffers returned words in
// fetch_fifo for the execution stage. A redirect from execution flushes both
// the buffer and any in-flight read.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   reset_pc             : first fetch address after reset
//   imem_req/imem_addr   : ITCM read request and word address
//   imem_rdata           : ITCM read data, one cycle after imem_req
//   inst_v_i/pc_i/inst_i : head of the queue towards execution
//   inst_rdy             : execution accepts the head
//   pc_v_x/pc_x          : redirect request and target from execution
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] reset_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_v_i,
    output logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] inst_i,
    input  logic            inst_rdy,
    input  logic            pc_v_x,
    input  logic [XLEN-1:0] pc_x
);

    import riscv_pkg::*;

    // XLEN must match riscv_pkg::XLEN since the buffered entry type uses it.
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  inflight_pc_r;
    logic             inflight_r;

    logic [CNT_W-1:0] count_s;
    logic [CNT_W:0]   occupancy_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic             head_v_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;

    // Issue/push decisions. Occupancy counts buffered entries plus the read in
    // flight, minus the entry leaving this cycle, so a full queue can keep
    // fetching at one word per cycle while execution drains it.
    always_comb begin
        pop_s       = head_v_s && inst_rdy;
        occupancy_s = {1'b0, count_s}
                    + {{CNT_W{1'b0}}, inflight_r}
                    - {{CNT_W{1'b0}}, pop_s};

        if (reset && !pc_v_x && (occupancy_s < (CNT_W + 1)'(DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        // A response racing a redirect or a reset is dropped.
        if (reset && !pc_v_x && inflight_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        push_entry_s.pc   = inflight_pc_r;
        push_entry_s.inst = imem_rdata;
    end

    // Fetch PC and in-flight tracking; redirect wins over normal issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r    <= word_align(reset_pc);
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (pc_v_x) begin
            fetch_pc_r    <= word_align(pc_x);
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            // Natural wrap modulo 2^XLEN.
            fetch_pc_r    <= fetch_pc_r + XLEN'(4);
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (pc_v_x),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .count     (count_s),
        .head_v    (head_v_s),
        .head      (head_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;
    assign inst_v_i  = head_v_s;
    assign pc_i      = head_s.pc;
    assign inst_i    = head_s.inst;

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue with a one-cycle-latency ITCM model whose
// contents are a fixed function of the address. Each cycle the inputs are
// changed 1 time unit after the rising edge and outputs are checked 1 unit
// later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] reset_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_v_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] inst_i;
    logic            inst_rdy;
    logic            pc_v_x;
    logic [XLEN-1:0] pc_x;

    int n_checks = 0;
    int n_errors = 0;
    int req_cnt;

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_pc   (reset_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_v_i   (inst_v_i),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .inst_rdy   (inst_rdy),
        .pc_v_x     (pc_v_x),
        .pc_x       (pc_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ITCM contents: an address-dependent pattern.
    function automatic logic [31:0] itcm_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    // ITCM model: data for a request appears the following cycle.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= itcm_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a new cycle with the given inputs, then settle before checking.
    task automatic drive(input logic rst, input logic rdy, input logic vx, input logic [31:0] x);
        @(posedge clk);
        #1;
        reset    = rst;
        inst_rdy = rdy;
        pc_v_x   = vx;
        pc_x     = x;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, "_v"},    {31'd0, inst_v_i}, 32'd1);
        check({tag, "_pc"},   pc_i,              pc);
        check({tag, "_inst"}, inst_i,            itcm_word(pc));
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"},  {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr,         addr);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_v"}, {31'd0, inst_v_i}, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        reset_pc = 32'h8000_0000;
        inst_rdy = 1'b1;
        pc_v_x   = 1'b0;
        pc_x     = 32'h0000_0000;

        // Reset state.
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("rst_v",    {31'd0, inst_v_i}, 32'd0);
        check("rst_req",  {31'd0, imem_req}, 32'd0);
        check("rst_pc",   pc_i,              32'h0000_0000);
        check("rst_inst", inst_i,            32'h0000_0000);

        // Cycles 0..4 after release: first request, then one head per cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_req("c0", 32'h8000_0000);
        expect_idle("c0");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_req("c1", 32'h8000_0004);
        expect_idle("c1");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("c2", 32'h8000_0000);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("c3", 32'h8000_0004);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("c4", 32'h8000_0008);

        // Backpressure for 10 cycles: the queue fills from the in-flight read
        // and no new request is allowed.
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_req) req_cnt++;
            expect_head("stall", 32'h8000_000C);
        end
        check("stall_reqs", req_cnt, 32'd0);

        // Release: continues without gap, loss or duplicate.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            expect_head("resume", 32'h8000_000C + 32'(4 * k));
        end

        // Redirect while queue plus in-flight read is at capacity (stalled).
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0102);
        check("redir_req", {31'd0, imem_req}, 32'd0);
        expect_head("redir_head", 32'h8000_001C);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("redir_r1");
        expect_req("redir_r1", 32'h8000_0100);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("redir_r2");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("redir_r3", 32'h8000_0100);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("redir_r4", 32'h8000_0104);

        // Redirect together with a pop, then a second redirect next cycle.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        expect_head("b2b_pop", 32'h8000_0108);
        check("b2b_req0", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_2004);
        expect_idle("b2b_r0");
        check("b2b_req1", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("b2b_r1");
        expect_req("b2b_r1", 32'h0000_2004);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("b2b_r2");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("b2b_r3", 32'h0000_2004);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("b2b_r4", 32'h0000_2008);

        // One-cycle reset with a read in flight and a redirect that must be
        // ignored; fetch restarts at the new reset_pc and wraps past the top.
        reset_pc = 32'hFFFF_FFF8;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_5000);
        check("mrst_req", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("mrst_c0");
        check("mrst_pc0",   pc_i,   32'h0000_0000);
        check("mrst_inst0", inst_i, 32'h0000_0000);
        expect_req("mrst_c0", 32'hFFFF_FFF8);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_idle("mrst_c1");
        expect_req("mrst_c1", 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("wrap_c2", 32'hFFFF_FFF8);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("wrap_c3", 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("wrap_c4", 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
